// File: rtl/cache_ctrl.sv
// Control stage in front of a direct-mapped 32x4-word cache array: hit/miss decode,
// CPU stall, memory handshake for line fills and write-through stores, hit/miss stats.
module cache_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic [9:0]         address,
    input  logic [31:0]        cpu_wdata,
    input  logic               valid,
    input  logic [2:0]         cash_tagged,
    output logic               refill,
    output logic               update,
    output logic [127:0]       main_data,
    output logic               stall,
    output logic               mem_rd_req,
    output logic               mem_wr_req,
    output logic [9:0]         mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ready,
    input  logic [127:0]       mem_rdata,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        REFILL,
        WR_MEM
    } state_t;

    state_t state;
    logic   replay;
    logic   wr_hit;
    logic   hit;
    logic   accept;

    assign hit = valid && (cash_tagged == address[9:7]);

    // The read replayed after a refill is the same CPU access, so it is not counted twice.
    assign accept = (state == IDLE) && (cpu_rd || cpu_wr) && !replay;

    // Write-through: the array word is only touched when the store hit a resident line.
    assign update = (state == WR_MEM) && mem_ready && wr_hit;

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = cpu_wr || (cpu_rd && !hit);
            RD_MISS: stall = 1'b1;
            REFILL:  stall = 1'b1;
            WR_MEM:  stall = !mem_ready;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            replay     <= 1'b0;
            wr_hit     <= 1'b0;
            main_data  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            refill     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    replay <= 1'b0;
                    if (cpu_wr) begin
                        mem_addr   <= address;
                        mem_wdata  <= cpu_wdata;
                        wr_hit     <= hit;
                        mem_wr_req <= 1'b1;
                        state      <= WR_MEM;
                    end else if (cpu_rd && !hit) begin
                        mem_addr   <= {address[9:2], 2'b00};
                        mem_rd_req <= 1'b1;
                        state      <= RD_MISS;
                    end
                end
                RD_MISS: begin
                    if (mem_ready) begin
                        main_data  <= mem_rdata;
                        mem_rd_req <= 1'b0;
                        refill     <= 1'b1;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    refill <= 1'b0;
                    replay <= 1'b1;
                    state  <= IDLE;
                end
                WR_MEM: begin
                    if (mem_ready) begin
                        mem_wr_req <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_cnt != {CNT_W{1'b1}})
                    hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
                if (miss_cnt != {CNT_W{1'b1}})
                    miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: cold read miss and refill, read hit, write hit/miss,
// reset during a fill, and counter saturation on a narrow-counter instance.
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_rd, cpu_wr;
    logic [9:0]   address;
    logic [31:0]  cpu_wdata;
    logic         valid;
    logic [2:0]   cash_tagged;
    logic         refill, update, stall;
    logic [127:0] main_data;
    logic         mem_rd_req, mem_wr_req;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic [15:0]  hit_cnt, miss_cnt;

    logic         cpu_rd2;
    logic [9:0]   address2;
    logic         refill2, update2, stall2;
    logic [127:0] main_data2;
    logic         mem_rd_req2, mem_wr_req2;
    logic [9:0]   mem_addr2;
    logic [31:0]  mem_wdata2;
    logic [1:0]   hit_cnt2, miss_cnt2;

    int vectors = 0;
    int miscompares = 0;

    // Minimal tag/valid store standing in for the cache array.
    logic       arr_valid [32];
    logic [2:0] arr_tag   [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) arr_valid[i] <= 1'b0;
        end else if (refill) begin
            arr_valid[address[6:2]] <= 1'b1;
            arr_tag[address[6:2]]   <= address[9:7];
        end
    end

    assign valid       = arr_valid[address[6:2]];
    assign cash_tagged = arr_tag[address[6:2]];

    always #5 clk = ~clk;

    cache_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .address(address),
        .cpu_wdata(cpu_wdata), .valid(valid), .cash_tagged(cash_tagged),
        .refill(refill), .update(update), .main_data(main_data), .stall(stall),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd2), .cpu_wr(1'b0), .address(address2),
        .cpu_wdata(32'h0), .valid(1'b1), .cash_tagged(address2[9:7]),
        .refill(refill2), .update(update2), .main_data(main_data2), .stall(stall2),
        .mem_rd_req(mem_rd_req2), .mem_wr_req(mem_wr_req2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_ready(1'b0), .mem_rdata(128'h0),
        .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
    );

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; address = '0; cpu_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0; cpu_rd2 = 1'b0; address2 = 10'h155;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        settle();
        check_output("reset_stall", stall, 0);
        check_output("reset_rd_req", mem_rd_req, 0);
        check_output("reset_wr_req", mem_wr_req, 0);
        check_output("reset_refill", refill, 0);
        check_output("reset_main_data", main_data, 0);
        check_output("reset_hit_cnt", hit_cnt, 0);
        check_output("reset_miss_cnt", miss_cnt, 0);

        // Cold read miss: detect cycle, three RD_MISS cycles, one REFILL cycle.
        next_cycle();
        cpu_rd = 1'b1; address = 10'h0A5;
        settle();
        check_output("rdmiss_detect_stall", stall, 1);
        next_cycle();
        settle();
        check_output("rdmiss_req", mem_rd_req, 1);
        check_output("rdmiss_addr", mem_addr, 10'h0A4);
        check_output("rdmiss_stall", stall, 1);
        check_output("rdmiss_miss_cnt", miss_cnt, 1);
        next_cycle();
        next_cycle();
        mem_ready = 1'b1;
        mem_rdata = 128'h44444444_33333333_22222222_11111111;
        settle();
        check_output("rdmiss_refill_early", refill, 0);
        next_cycle();
        mem_ready = 1'b0;
        settle();
        check_output("refill_pulse", refill, 1);
        check_output("refill_stall", stall, 1);
        check_output("refill_rd_req_low", mem_rd_req, 0);
        check_output("refill_line", main_data, 128'h44444444_33333333_22222222_11111111);
        next_cycle();
        settle();
        check_output("replay_stall", stall, 0);
        check_output("replay_refill_low", refill, 0);

        // Fresh read of the same word hits.
        next_cycle();
        settle();
        check_output("after_replay_miss_cnt", miss_cnt, 1);
        check_output("after_replay_hit_cnt", hit_cnt, 0);
        check_output("rdhit_stall", stall, 0);
        next_cycle();
        cpu_rd = 1'b0;
        settle();
        check_output("rdhit_hit_cnt", hit_cnt, 1);

        // Write hit, memory completes in the second WR_MEM cycle.
        cpu_wr = 1'b1; address = 10'h0A6; cpu_wdata = 32'hDEADBEEF;
        settle();
        check_output("wrhit_accept_stall", stall, 1);
        next_cycle();
        settle();
        check_output("wrhit_req", mem_wr_req, 1);
        check_output("wrhit_addr", mem_addr, 10'h0A6);
        check_output("wrhit_wdata", mem_wdata, 32'hDEADBEEF);
        check_output("wrhit_update_early", update, 0);
        check_output("wrhit_stall", stall, 1);
        check_output("wrhit_hit_cnt", hit_cnt, 2);
        next_cycle();
        mem_ready = 1'b1;
        settle();
        check_output("wrhit_update", update, 1);
        check_output("wrhit_stall_drop", stall, 0);
        next_cycle();
        mem_ready = 1'b0;
        // Write miss: same index, tag 7.
        address = 10'h3A6; cpu_wdata = 32'h0BADF00D;
        settle();
        check_output("wrhit_update_after", update, 0);
        check_output("wrhit_req_after", mem_wr_req, 0);
        next_cycle();
        mem_ready = 1'b1;
        settle();
        check_output("wrmiss_req", mem_wr_req, 1);
        check_output("wrmiss_addr", mem_addr, 10'h3A6);
        check_output("wrmiss_update", update, 0);
        check_output("wrmiss_refill", refill, 0);
        check_output("wrmiss_miss_cnt", miss_cnt, 2);
        next_cycle();
        mem_ready = 1'b0; cpu_wr = 1'b0;
        settle();
        check_output("wrmiss_refill_after", refill, 0);
        check_output("wrmiss_hit_cnt", hit_cnt, 2);

        // Reset while a line fill is in flight.
        cpu_rd = 1'b1; address = 10'h100;
        next_cycle();
        settle();
        check_output("rst_test_rd_req", mem_rd_req, 1);
        check_output("rst_test_miss_cnt", miss_cnt, 3);
        rst = 1'b1; cpu_rd = 1'b0;
        next_cycle();
        rst = 1'b0; mem_ready = 1'b1; mem_rdata = 128'hAAAA;
        settle();
        check_output("rst_rd_req_drop", mem_rd_req, 0);
        check_output("rst_stall", stall, 0);
        check_output("rst_hit_cnt", hit_cnt, 0);
        check_output("rst_miss_cnt", miss_cnt, 0);
        next_cycle();
        mem_ready = 1'b0;
        settle();
        check_output("rst_refill", refill, 0);
        check_output("rst_main_data", main_data, 0);
        check_output("rst_rd_req_idle", mem_rd_req, 0);

        // Narrow counters saturate at 3.
        cpu_rd2 = 1'b1;
        settle();
        check_output("sat_stall", stall2, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        check_output("sat_hit_cnt_3", hit_cnt2, 3);
        next_cycle();
        next_cycle();
        cpu_rd2 = 1'b0;
        check_output("sat_hit_cnt_hold", hit_cnt2, 3);
        check_output("sat_miss_cnt", miss_cnt2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Control stage directly upstream of the direct-mapped cache array (32 lines × 4 words, 3-bit tag, 10-bit word address). It decodes hit/miss from the array's `valid`/`cash_tagged` outputs and drives the array's `refill`/`update` strobes. It stalls the CPU, runs the main-memory handshake for line fills and write-through stores, buffers the returned 128-bit line onto the array's `main_data`, and keeps saturating hit/miss counters. Policy: write-through, no-write-allocate.

## Interface
- `CNT_W`, 16, width of the hit/miss counters
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `cpu_rd` in 1: CPU load request; held until the cycle `stall`=0
- `cpu_wr` in 1: CPU store request; same hold rule
- `address` in 10: CPU word address (tag [9:7], index [6:2], offset [1:0]); also wired straight to the array; CPU holds it while `stall`=1
- `cpu_wdata` in 32: store data; also wired to the array's `write_data`
- `valid` in 1: from array, line valid at `address` index
- `cash_tagged` in 3: from array, stored tag at `address` index
- `refill` out 1: array line-fill strobe
- `update` out 1: array word-write strobe
- `main_data` out 128: buffered line to array
- `stall` out 1: CPU freeze, combinational
- `mem_rd_req` out 1: line-read request to memory
- `mem_wr_req` out 1: word-write request to memory
- `mem_addr` out 10: memory word address
- `mem_wdata` out 32: store data to memory
- `mem_ready` in 1: one-cycle memory completion pulse
- `mem_rdata` in 128: line from memory, valid when `mem_ready`=1 during a read
- `hit_cnt` out CNT_W: read+write hits
- `miss_cnt` out CNT_W: read+write misses

## Operation
- `hit` = `valid` && (`cash_tagged` == `address[9:7]`), combinational.
- States: IDLE, RD_MISS, REFILL, WR_MEM.
- IDLE:
  - `cpu_wr`=1 wins over `cpu_rd`. Latch `address` and `cpu_wdata` into `mem_addr` and `mem_wdata`, latch `hit` into `wr_hit`, then go to WR_MEM. `stall`=1.
  - `cpu_rd`=1 with hit: `stall`=0 and stay in IDLE; the array supplies read data combinationally.
  - `cpu_rd`=1 with miss: `stall`=1. Latch `mem_addr`={`address[9:2]`,2'b00}, then go to RD_MISS.
  - No request: `stall`=0.
  - `mem_ready` is ignored in IDLE.
- RD_MISS: `mem_rd_req`=1 and `stall`=1. On `mem_ready`, capture `mem_rdata` into the line buffer (`main_data`) and go to REFILL.
- REFILL: `refill`=1 for exactly one cycle and `stall`=1; the array writes the line, tag and valid at the closing edge. Set `replay`, then go to IDLE. The CPU's held read then hits in IDLE.
- WR_MEM: `mem_wr_req`=1 and `stall`=!`mem_ready`. On `mem_ready`: `update`=`wr_hit` for that cycle, then go to IDLE. The CPU advances at that same edge. A write miss never sets `refill` or `update`.
- Counters, on each IDLE access acceptance with `replay`=0:
  - Hit increments `hit_cnt`; miss increments `miss_cnt`.
  - Both saturate at 2^CNT_W−1.
  - `replay` clears after the first IDLE cycle. The replayed read is not counted.
- `update` and `refill` are never high together. At most one of `mem_rd_req`/`mem_wr_req` is high.

## Timing
- Reset values: state=IDLE, `replay`=0, `wr_hit`=0, `main_data`=0, `mem_addr`=0, `mem_wdata`=0, `hit_cnt`=`miss_cnt`=0. All request and strobe outputs are 0. `stall` follows the IDLE rules.
- Reset has priority in any state. An in-flight memory request drops in the next cycle, and a `mem_ready` pulse arriving in that cycle is ignored.
- Read hit: 0 stall cycles.
- Read miss: stall cycles = 1 (IDLE detect) + N (RD_MISS, up to and including the `mem_ready` cycle) + 1 (REFILL). Data is returned in the following IDLE cycle.
- Write (hit or miss): stall cycles = 1 + N − 1. `stall` drops in the `mem_ready` cycle.
- `mem_ready` in the same cycle as a state entry is sampled normally (N≥1).
- Back-to-back accesses: a new request is accepted in the cycle after `stall` falls, with no bubble required.

## Test plan
- Reset, then `cpu_rd` to 10'h0A5 on a cold cache, with `mem_ready` 3 cycles later and `mem_rdata`=128'h4444…_1111: `mem_rd_req` is asserted with `mem_addr`=10'h0A4, `refill` pulses once, and the next IDLE cycle has `stall`=0. `miss_cnt`=1, `hit_cnt`=0.
- Repeat the read of 10'h0A5: `stall`=0 that cycle and `hit_cnt`=1.
- `cpu_wr` 10'h0A6 with data 32'hDEADBEEF (hit), `mem_ready` after 2 cycles: `mem_wr_req` is asserted with `mem_addr`=10'h0A6 and `mem_wdata`=32'hDEADBEEF. `update`=1 only in the `mem_ready` cycle. `hit_cnt`=2.
- `cpu_wr` to 10'h3A6 (same index, tag 7, miss): the memory write completes, `update`=0 and `refill`=0. `miss_cnt`=2.
- Assert `rst` while in RD_MISS, then pulse `mem_ready`: state=IDLE, `refill` never asserts, and both counters read 0.
- With `CNT_W`=2, perform 5 read hits: `hit_cnt` stops at 3.
